// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, transmit FSM states and the divisor floor.
package uart_pkg;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_DIV    = 2'd2;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_W   = 5;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // A bit period below two cycles cannot be timed by the bit counter.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus as seen between the core (master) and a responder (slave).
interface uart_tx_mmio_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        hit;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        output mem_rstrb,
        input  mem_rdata,
        input  hit
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        input  mem_rstrb,
        output mem_rdata,
        output hit
    );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with show-ahead read port; a push while full only
// lands when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage is deliberately not reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers on the core
// data bus, a TX FIFO, and a serializer with a programmable bit period.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rstn,
    uart_tx_mmio_if.slave  bus,
    output logic           uart_tx
);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DIV_RAW = CLK_HZ / BAUD;
    localparam logic [15:0] DIV_RST = (DIV_RAW < 32'(DIV_MIN)) ? DIV_MIN : 16'(DIV_RAW);

    // Bus decode
    logic [1:0]  offset;
    logic        wr_en;
    logic        data_wr;
    logic        status_wr;
    logic        div_wr;
    logic [15:0] div_merged;

    // Registers
    logic [15:0] div;
    logic        overflow;
    logic [31:0] rdata_q;
    logic [31:0] status_word;
    logic [31:0] reg_rdata;

    // FIFO
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Serializer
    tx_state_t   state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic [15:0] bit_div, bit_div_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic        tx_q, tx_nxt;
    logic        timer_end;
    logic        busy;

    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata[31:16], bus.mem_wmask[3:2]};

    assign bus.hit   = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = bus.mem_addr[3:2];
    assign wr_en     = bus.hit & (|bus.mem_wmask);
    assign data_wr   = wr_en & (offset == OFS_DATA) & bus.mem_wmask[0];
    assign status_wr = wr_en & (offset == OFS_STATUS) & bus.mem_wmask[0];
    assign div_wr    = wr_en & (offset == OFS_DIV) & (|bus.mem_wmask[1:0]);
    assign push      = data_wr & (~fifo_full | pop);

    assign div_merged = {bus.mem_wmask[1] ? bus.mem_wdata[15:8] : div[15:8],
                         bus.mem_wmask[0] ? bus.mem_wdata[7:0]  : div[7:0]};

    assign busy          = (state != IDLE);
    assign uart_tx       = tx_q;
    assign bus.mem_rdata = rdata_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (bus.mem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word                               = '0;
        status_word[ST_BUSY]                      = busy;
        status_word[ST_FULL]                      = fifo_full;
        status_word[ST_EMPTY]                     = fifo_empty;
        status_word[ST_OVF]                       = overflow;
        status_word[ST_CNT_LSB +: ST_CNT_W]       = ST_CNT_W'(fifo_count);
    end

    always_comb begin
        reg_rdata = '0;
        case (offset)
            OFS_STATUS: reg_rdata = status_word;
            OFS_DIV:    reg_rdata = {16'd0, div};
            default:    reg_rdata = '0;
        endcase
    end

    // Register file and read-data capture; DIV writes only reach the serializer on its next pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div      <= DIV_RST;
            overflow <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (div_wr) begin
                div <= clamp_div(div_merged);
            end
            if (data_wr && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (status_wr && bus.mem_wdata[ST_OVF]) begin
                overflow <= 1'b0;
            end
            if (bus.mem_rstrb) begin
                rdata_q <= bus.hit ? reg_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            timer   <= '0;
            bit_div <= DIV_RST;
            shift   <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_div <= bit_div_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx_q    <= tx_nxt;
        end
    end

    assign timer_end = (timer == (bit_div - 16'd1));

    // Frame sequencing; a pop from IDLE or at the end of STOP starts the start bit on the same edge.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_div_nxt = bit_div;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = tx_q;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_nxt   = fifo_dout;
                    bit_div_nxt = div;
                    timer_nxt   = '0;
                    tx_nxt      = 1'b0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (timer_end) begin
                    timer_nxt   = '0;
                    bit_cnt_nxt = '0;
                    tx_nxt      = shift[0];
                    state_nxt   = DATA;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            DATA: begin
                if (timer_end) begin
                    timer_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt   = {1'b0, shift[7:1]};
                        tx_nxt      = shift[1];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            STOP: begin
                if (timer_end) begin
                    timer_nxt = '0;
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shift_nxt   = fifo_dout;
                        bit_div_nxt = div;
                        tx_nxt      = 1'b0;
                        state_nxt   = START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized bench for uart_tx_mmio: a queue-based model of the FIFO and the
// serial line is checked against the DUT every cycle, plus directed literal checks.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE  = 32'h0000_8000;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rstn;
    logic uart_tx;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLK_HZ     (1000000),
        .BAUD       (100000),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: pending bytes, and the line level for every remaining cycle of queued frames.
    byte unsigned mq[$];
    bit           mline[$];
    bit           m_tx;
    bit           m_busy;
    bit           m_ovf;
    int unsigned  m_div;
    logic [31:0]  m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0]   = m_busy;
        s[1]   = (mq.size() == DEPTH);
        s[2]   = (mq.size() == 0);
        s[3]   = m_ovf;
        s[8:4] = 5'(mq.size());
        return s;
    endfunction

    task automatic model_step();
        logic        hit_now;
        logic [1:0]  off;
        logic [15:0] nd;
        byte unsigned b;
        bit v;
        hit_now = (bus.mem_addr[31:4] == BASE[31:4]);
        off     = bus.mem_addr[3:2];
        if (bus.mem_rstrb) begin
            if (!hit_now)        m_rdata = '0;
            else if (off == 2'd1) m_rdata = model_status();
            else if (off == 2'd2) m_rdata = m_div;
            else                  m_rdata = '0;
        end
        if (mline.size() == 0 && mq.size() != 0) begin
            b = mq.pop_front();
            for (int k = 0; k < 10; k++) begin
                v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                for (int c = 0; c < int'(m_div); c++) mline.push_back(v);
            end
        end
        if (hit_now && bus.mem_wmask != 4'd0) begin
            if (off == 2'd0 && bus.mem_wmask[0]) begin
                if (mq.size() < DEPTH) mq.push_back(bus.mem_wdata[7:0]);
                else                   m_ovf = 1'b1;
            end else if (off == 2'd1 && bus.mem_wmask[0] && bus.mem_wdata[3]) begin
                m_ovf = 1'b0;
            end else if (off == 2'd2 && bus.mem_wmask[1:0] != 2'd0) begin
                nd = 16'(m_div);
                if (bus.mem_wmask[0]) nd[7:0]  = bus.mem_wdata[7:0];
                if (bus.mem_wmask[1]) nd[15:8] = bus.mem_wdata[15:8];
                m_div = (nd < 16'd2) ? 2 : int'(nd);
            end
        end
        if (mline.size() != 0) begin
            m_tx   = mline.pop_front();
            m_busy = 1'b1;
        end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            mline.delete();
            m_tx    = 1'b1;
            m_busy  = 1'b0;
            m_ovf   = 1'b0;
            m_div   = 10;
            m_rdata = '0;
        end else begin
            model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rstn && chk_en) begin
            check("uart_tx", 32'(uart_tx), 32'(m_tx));
            check("mem_rdata", bus.mem_rdata, m_rdata);
            check("hit", 32'(bus.hit), 32'(bus.mem_addr[31:4] == BASE[31:4]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_rw(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic rd);
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        bus.mem_wmask = mask;
        bus.mem_rstrb = rd;
        step();
        bus.mem_wmask = 4'd0;
        bus.mem_rstrb = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        bus_rw(addr, data, mask, 1'b0);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] r);
        bus_rw(addr, 32'd0, 4'd0, 1'b1);
        r = bus.mem_rdata;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mq.size() != 0 || mline.size() != 0 || m_busy) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: got timeout after %0d cycles, required idle", n);
        end
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [9:0]  pat;
        logic [3:0]  m;
        int          op;

        rstn          = 1'b0;
        bus.mem_addr  = BASE;
        bus.mem_wdata = '0;
        bus.mem_wmask = 4'd0;
        bus.mem_rstrb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn   = 1'b1;
        chk_en = 1'b1;

        check("reset uart_tx", 32'(uart_tx), 32'd1);
        check("reset mem_rdata", bus.mem_rdata, 32'd0);
        bus_read(BASE + 32'd4, r);
        check("reset STATUS", r, 32'h004);
        bus_read(BASE + 32'd8, r);
        check("reset DIV", r, 32'd10);

        // Single frame 0x55 at 10 cycles per bit, sampled mid-bit.
        pat = {1'b1, 8'h55, 1'b0};
        bus_write(BASE, 32'h55, 4'b0001);
        step();
        for (int c = 0; c < 100; c++) begin
            if (c % 10 == 5) check($sformatf("0x55 bit%0d", c / 10), 32'(uart_tx), 32'(pat[c / 10]));
            step();
        end
        step();
        bus_read(BASE + 32'd4, r);
        check("STATUS after frame", r, 32'h004);

        // Six back-to-back writes into a depth-4 FIFO.
        for (int i = 0; i < 6; i++) bus_write(BASE, 32'h41 + 32'(i), 4'b0001);
        bus_read(BASE + 32'd4, r);
        check("STATUS full+overflow", r, 32'h04B);
        bus_write(BASE + 32'd4, 32'h8, 4'b0001);
        bus_read(BASE + 32'd4, r);
        check("STATUS overflow cleared", r, 32'h043);
        wait_idle();

        // Divisor clamp and a mid-frame divisor change.
        bus_write(BASE + 32'd8, 32'd1, 4'b0011);
        bus_read(BASE + 32'd8, r);
        check("DIV clamp", r, 32'd2);
        bus_write(BASE + 32'd8, 32'd10, 4'b0011);
        bus_write(BASE, 32'hA5, 4'b0001);
        bus_write(BASE, 32'h3C, 4'b0001);
        repeat (30) step();
        bus_write(BASE + 32'd8, 32'd20, 4'b0011);
        wait_idle();
        bus_read(BASE + 32'd8, r);
        check("DIV readback 20", r, 32'd20);

        // Reset while a zero data bit is on the line.
        bus_write(BASE + 32'd8, 32'd10, 4'b0011);
        bus_write(BASE, 32'hF0, 4'b0001);
        repeat (35) step();
        check("pre-reset line low", 32'(uart_tx), 32'd0);
        rstn = 1'b0;
        #1;
        check("async reset uart_tx", 32'(uart_tx), 32'd1);
        step();
        step();
        rstn = 1'b1;
        bus_read(BASE + 32'd4, r);
        check("STATUS after reset", r, 32'h004);
        bus_read(BASE + 32'd8, r);
        check("DIV after reset", r, 32'd10);

        // Unmapped read returns zero and does not hit.
        bus.mem_addr  = BASE - 32'd4;
        bus.mem_rstrb = 1'b1;
        #1;
        check("unmapped hit", 32'(bus.hit), 32'd0);
        step();
        bus.mem_rstrb = 1'b0;
        check("unmapped rdata", bus.mem_rdata, 32'd0);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 9));
            m  = 4'($urandom);
            case (op)
                0, 1, 2: bus_rw(BASE, $urandom, m | 4'b0001, 1'($urandom));
                3:       bus_rw(BASE, $urandom, m, 1'($urandom));
                4:       bus_rw(BASE + 32'(4 * $urandom_range(0, 3)), 32'd0, 4'd0, 1'b1);
                5:       bus_rw(BASE + 32'd8, (32'($urandom) & 32'hFFFF_0000) | 32'($urandom_range(0, 14)),
                                m, 1'($urandom));
                6:       bus_rw(BASE + 32'd4, $urandom, m, 1'($urandom));
                7:       bus_rw(($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 64))
                                                             : BASE + 32'(16 * $urandom_range(1, 64)),
                                $urandom, m, 1'b1);
                8:       bus_rw(BASE + 32'd12, $urandom, m, 1'($urandom));
                default: repeat ($urandom_range(1, 40)) step();
            endcase
        end
        wait_idle();
        bus_read(BASE + 32'd4, r);
        check("final STATUS idle", r & 32'h1F7, 32'h004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
